// File: rtl/multicycle_cpu.sv
// Multi-cycle MIPS-subset core with one shared instruction/data memory port.
// Each memory access waits for mem_ready, so any number of wait states is tolerated.
module multicycle_cpu #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ready,
   input  logic [31:0]       mem_rdata,
   output logic [31:0]       pc_out,
   output logic [3:0]        state_out,
   output logic              retire,
   output logic              halted
);

   typedef enum logic [3:0] {
      StFetch  = 4'd0,
      StDecode = 4'd1,
      StMemAdr = 4'd2,
      StMemRd  = 4'd3,
      StMemWb  = 4'd4,
      StMemWr  = 4'd5,
      StExec   = 4'd6,
      StAluWb  = 4'd7,
      StBranch = 4'd8,
      StAddiEx = 4'd9,
      StAddiWb = 4'd10,
      StJump   = 4'd11,
      StHalt   = 4'd15
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, ir_q, a_q, b_q, alu_q, mdr_q, tgt_q;
   logic [31:0] rf_q [32];
   logic        retire_q;

   // Instruction fields
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [31:0] sext;
   assign op    = ir_q[31:26];
   assign rs    = ir_q[25:21];
   assign rt    = ir_q[20:16];
   assign rd    = ir_q[15:11];
   assign shamt = ir_q[10:6];
   assign funct = ir_q[5:0];
   assign sext  = {{16{ir_q[15]}}, ir_q[15:0]};

   // Register reads; $0 is forced to zero regardless of storage
   logic [31:0] rf_rs, rf_rt;
   assign rf_rs = (rs == 5'd0) ? 32'd0 : rf_q[rs];
   assign rf_rt = (rt == 5'd0) ? 32'd0 : rf_q[rt];

   // R-type ALU; funct_ok flags the supported function codes
   logic [31:0] alu_res;
   logic        funct_ok;
   always_comb begin
      alu_res  = '0;
      funct_ok = 1'b1;
      unique case (funct)
         6'h20:   alu_res = a_q + b_q;
         6'h22:   alu_res = a_q - b_q;
         6'h24:   alu_res = a_q & b_q;
         6'h25:   alu_res = a_q | b_q;
         6'h2A:   alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
         6'h00:   alu_res = b_q << shamt;
         default: funct_ok = 1'b0;
      endcase
   end

   // Next-state and memory-port request decode
   logic        req, we;
   logic [31:0] addr, wdata;
   always_comb begin
      state_d = state_q;
      req     = 1'b0;
      we      = 1'b0;
      addr    = '0;
      wdata   = '0;
      unique case (state_q)
         StFetch: begin
            req  = 1'b1;
            addr = pc_q;
            if (mem_ready) state_d = StDecode;
         end
         StDecode: begin
            unique case (op)
               6'h00:        state_d = StExec;
               6'h23, 6'h2B: state_d = StMemAdr;
               6'h04:        state_d = StBranch;
               6'h08:        state_d = StAddiEx;
               6'h02:        state_d = StJump;
               default:      state_d = StHalt;
            endcase
         end
         StMemAdr: state_d = (op == 6'h23) ? StMemRd : StMemWr;
         StMemRd: begin
            req  = 1'b1;
            addr = alu_q;
            if (mem_ready) state_d = StMemWb;
         end
         StMemWb: state_d = StFetch;
         StMemWr: begin
            req   = 1'b1;
            we    = 1'b1;
            addr  = alu_q;
            wdata = b_q;
            if (mem_ready) state_d = StFetch;
         end
         StExec:   state_d = funct_ok ? StAluWb : StHalt;
         StAluWb:  state_d = StFetch;
         StBranch: state_d = StFetch;
         StAddiEx: state_d = StAddiWb;
         StAddiWb: state_d = StFetch;
         StJump:   state_d = StFetch;
         StHalt:   state_d = StHalt;
         default:  state_d = StHalt;
      endcase
   end

   // Port outputs; gated by reset so they read zero the moment reset asserts
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (reset) begin
         mem_req   = req;
         mem_we    = we;
         mem_addr  = addr[ADDR_W-1:0];
         mem_wdata = wdata;
      end
   end

   // State register and retire pulse (any final state returning to FETCH)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StFetch;
         retire_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         retire_q <= (state_q != StFetch) && (state_d == StFetch);
      end
   end

   // Datapath registers: PC, IR, operand latches, ALUOut, MDR, branch target
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q  <= RESET_PC;
         ir_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         alu_q <= '0;
         mdr_q <= '0;
         tgt_q <= '0;
      end else begin
         unique case (state_q)
            StFetch: if (mem_ready) begin
               ir_q <= mem_rdata;
               pc_q <= pc_q + 32'd4;
            end
            StDecode: begin
               a_q   <= rf_rs;
               b_q   <= rf_rt;
               tgt_q <= pc_q + {sext[29:0], 2'b00};
            end
            StMemAdr, StAddiEx: alu_q <= a_q + sext;
            StExec:             alu_q <= alu_res;
            StMemRd:            if (mem_ready) mdr_q <= mem_rdata;
            StBranch:           if (a_q == b_q) pc_q <= tgt_q;
            StJump:             pc_q <= {pc_q[31:28], ir_q[25:0], 2'b00};
            default: ;
         endcase
      end
   end

   // Register file write-back port
   logic        rf_we;
   logic [4:0]  rf_idx;
   logic [31:0] rf_wd;
   always_comb begin
      rf_we  = 1'b0;
      rf_idx = '0;
      rf_wd  = '0;
      unique case (state_q)
         StMemWb:  begin rf_we = 1'b1; rf_idx = rt; rf_wd = mdr_q; end
         StAluWb:  begin rf_we = 1'b1; rf_idx = rd; rf_wd = alu_q; end
         StAddiWb: begin rf_we = 1'b1; rf_idx = rt; rf_wd = alu_q; end
         default: ;
      endcase
   end

   // Register file storage; writes to $0 are dropped
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else if (rf_we && (rf_idx != 5'd0)) begin
         rf_q[rf_idx] <= rf_wd;
      end
   end

   assign pc_out    = pc_q;
   assign state_out = state_q;
   assign retire    = retire_q;
   assign halted    = (state_q == StHalt);

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: wait-state memory model, retire/cycle monitor.
module tb_multicycle_cpu;

   localparam logic [31:0] BOOT   = 32'h0000_0080;
   localparam logic [31:0] HALT_W = 32'hFC00_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        mem_req, mem_we, mem_ready, retire, halted;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
   logic [3:0]  state_out;

   multicycle_cpu #(.RESET_PC(BOOT), .ADDR_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .pc_out    (pc_out),
      .state_out (state_out),
      .retire    (retire),
      .halted    (halted)
   );

   always #5 clk = ~clk;

   // Memory model: 128 words, fixed number of wait cycles per request
   logic [31:0] mem [128];
   logic        clr = 1'b0, ld_we = 1'b0;
   logic [6:0]  ld_idx = '0;
   logic [31:0] ld_dat = '0;
   int          wait_n = 0;
   int          wcnt;

   always @(posedge clk) begin
      if (clr) for (int i = 0; i < 128; i++) mem[i] <= HALT_W;
      else if (ld_we) mem[ld_idx] <= ld_dat;
      else if (mem_req && mem_we && mem_ready) mem[mem_addr[8:2]] <= mem_wdata;
   end

   always @(posedge clk or negedge reset) begin
      if (!reset) wcnt <= 0;
      else if (mem_req) wcnt <= mem_ready ? 0 : wcnt + 1;
   end

   assign mem_ready = mem_req && (wcnt >= wait_n);
   assign mem_rdata = mem[mem_addr[8:2]];

   // Monitor: cycle count, retire log, request stability, requests while halted
   int          cyc, ret_cnt, stab_n, stab_err, halt_req;
   int          ret_cyc [16];
   logic [31:0] ret_pc [16];
   logic        pend;
   logic        p_we;
   logic [31:0] p_addr, p_wdata;

   always @(posedge clk or negedge reset) begin
      if (!reset) cyc <= 0;
      else cyc <= cyc + 1;
   end

   always @(negedge clk or negedge reset) begin
      if (!reset) begin
         ret_cnt <= 0; stab_n <= 0; stab_err <= 0; halt_req <= 0; pend <= 1'b0;
      end else begin
         if (retire) begin
            if (ret_cnt < 16) begin
               ret_cyc[ret_cnt] <= cyc;
               ret_pc[ret_cnt]  <= pc_out;
            end
            ret_cnt <= ret_cnt + 1;
         end
         if (pend) begin
            stab_n <= stab_n + 1;
            if (!mem_req || mem_addr != p_addr || mem_we != p_we || mem_wdata != p_wdata)
               stab_err <= stab_err + 1;
         end
         pend    <= mem_req && !mem_ready;
         p_addr  <= mem_addr;
         p_we    <= mem_we;
         p_wdata <= mem_wdata;
         if (halted && mem_req) halt_req <= halt_req + 1;
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
      return {6'h00, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] jtype(input logic [25:0] t);
      return {6'h02, t};
   endfunction

   logic [31:0] pa;

   // Hold reset, set wait states, fill memory with halt words
   task automatic setup(input int w);
      reset  = 1'b0;
      wait_n = w;
      clr    = 1'b1;
      @(posedge clk); #1;
      clr    = 1'b0;
      pa     = BOOT;
   endtask

   task automatic poke(input logic [31:0] a, input logic [31:0] d);
      ld_we  = 1'b1;
      ld_idx = a[8:2];
      ld_dat = d;
      @(posedge clk); #1;
      ld_we  = 1'b0;
   endtask

   task automatic emit(input logic [31:0] w);
      poke(pa, w);
      pa = pa + 32'd4;
   endtask

   task automatic release_rst();
      @(negedge clk); #1;
      reset = 1'b1;
   endtask

   // Release reset and run until HALT, bounded
   task automatic run(input string tag);
      int n = 0;
      release_rst();
      while (!halted && n < 600) begin @(negedge clk); n++; end
      check(tag, {31'd0, halted}, 32'd1);
   endtask

   initial begin
      // Reset values
      setup(0);
      #1;
      check("rst_req",   {31'd0, mem_req}, 32'd0);
      check("rst_pc",    pc_out, BOOT);
      check("rst_state", {28'd0, state_out}, 32'd0);
      check("rst_flags", {30'd0, retire, halted}, 32'd0);

      // Zero-wait program
      setup(0);
      emit(itype(6'h08, 5'd0, 5'd1, 16'd5));
      emit(itype(6'h08, 5'd0, 5'd2, 16'd7));
      emit(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
      emit(itype(6'h2B, 5'd0, 5'd3, 16'd16));
      emit(itype(6'h23, 5'd0, 5'd4, 16'd16));
      emit(itype(6'h2B, 5'd0, 5'd4, 16'd20));
      run("p1_halt");
      check("p1_mem16",  mem[4], 32'd12);
      check("p1_r4",     mem[5], 32'd12);
      check("p1_retire", ret_cnt, 32'd6);
      check("p1_cyc1",   ret_cyc[0], 32'd4);
      check("p1_cyc5",   ret_cyc[4], 32'd21);

      // Taken beq after a jump into 0x20
      setup(0);
      emit(jtype(26'h8));
      poke(32'h20, itype(6'h04, 5'd1, 5'd1, 16'd2));
      run("b1_halt");
      check("b1_j_pc",   ret_pc[0], 32'h20);
      check("b1_j_cyc",  ret_cyc[0], 32'd3);
      check("b1_beq_pc", ret_pc[1], 32'h2C);
      check("b1_beq_cy", ret_cyc[1] - ret_cyc[0], 32'd3);

      // Untaken beq, then j 0x40 from 0x30
      setup(0);
      emit(itype(6'h08, 5'd0, 5'd1, 16'd1));
      emit(jtype(26'h8));
      poke(32'h20, itype(6'h04, 5'd1, 5'd2, 16'd2));
      poke(32'h24, jtype(26'hC));
      poke(32'h30, jtype(26'h40));
      run("b2_halt");
      check("b2_nt_pc",  ret_pc[2], 32'h24);
      check("b2_nt_cyc", ret_cyc[2] - ret_cyc[1], 32'd3);
      check("b2_j_pc",   ret_pc[4], 32'h100);
      check("b2_j_cyc",  ret_cyc[4] - ret_cyc[3], 32'd3);

      // Three wait states on every request
      setup(3);
      poke(32'h10, 32'h1234_5678);
      emit(itype(6'h23, 5'd0, 5'd4, 16'd16));
      emit(itype(6'h2B, 5'd0, 5'd4, 16'd20));
      run("w_halt");
      check("w_lw_cyc",  ret_cyc[0], 32'd11);
      check("w_r4",      mem[5], 32'h1234_5678);
      check("w_stab",    stab_err, 32'd0);
      check("w_waits",   {31'd0, stab_n >= 12}, 32'd1);

      // Reset during a stalled store to 0x50
      setup(4);
      poke(32'h50, 32'hDEAD_BEEF);
      emit(itype(6'h08, 5'd0, 5'd1, 16'h77));
      emit(itype(6'h2B, 5'd0, 5'd1, 16'h50));
      release_rst();
      begin
         int n = 0;
         while (state_out != 4'd5 && n < 100) begin @(negedge clk); n++; end
      end
      check("mr_in_wr",  {28'd0, state_out}, 32'd5);
      @(negedge clk); #2;
      reset = 1'b0;
      #1;
      check("mr_req",    {30'd0, mem_req, mem_we}, 32'd0);
      check("mr_addr",   mem_addr, 32'd0);
      check("mr_wdata",  mem_wdata, 32'd0);
      check("mr_pc",     pc_out, BOOT);
      check("mr_state",  {28'd0, state_out}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("mr_mem50",  mem[20], 32'hDEAD_BEEF);
      release_rst();
      #1;
      check("mr_fetch",  {31'd0, mem_req}, 32'd1);
      check("mr_faddr",  mem_addr, BOOT);
      check("mr_fwe",    {31'd0, mem_we}, 32'd0);

      // Illegal opcode 0x3F and illegal funct 0x27
      for (int k = 0; k < 2; k++) begin
         setup(0);
         emit(k == 0 ? HALT_W : rtype(5'd0, 5'd0, 5'd0, 5'd0, 6'h27));
         run("il_halt");
         repeat (10) @(negedge clk);
         check("il_state",  {28'd0, state_out}, 32'd15);
         check("il_halted", {31'd0, halted}, 32'd1);
         check("il_retire", ret_cnt, 32'd0);
         check("il_noreq",  halt_req, 32'd0);
      end

      // $0, slt, sub, or, and, sll
      setup(0);
      for (int i = 16; i < 23; i++) poke(32'(i * 4), 32'hAAAA_AAAA);
      emit(itype(6'h08, 5'd0, 5'd0, 16'd9));
      emit(itype(6'h08, 5'd0, 5'd1, 16'hFFFF));
      emit(itype(6'h08, 5'd0, 5'd2, 16'd1));
      emit(rtype(5'd1, 5'd2, 5'd6, 5'd0, 6'h2A));
      emit(rtype(5'd2, 5'd1, 5'd7, 5'd0, 6'h2A));
      emit(rtype(5'd2, 5'd1, 5'd8, 5'd0, 6'h22));
      emit(rtype(5'd2, 5'd8, 5'd9, 5'd0, 6'h25));
      emit(rtype(5'd9, 5'd8, 5'd10, 5'd0, 6'h24));
      emit(itype(6'h08, 5'd0, 5'd1, 16'd3));
      emit(rtype(5'd0, 5'd1, 5'd5, 5'd4, 6'h00));
      emit(itype(6'h2B, 5'd0, 5'd0, 16'h40));
      emit(itype(6'h2B, 5'd0, 5'd6, 16'h44));
      emit(itype(6'h2B, 5'd0, 5'd7, 16'h48));
      emit(itype(6'h2B, 5'd0, 5'd8, 16'h4C));
      emit(itype(6'h2B, 5'd0, 5'd9, 16'h50));
      emit(itype(6'h2B, 5'd0, 5'd5, 16'h54));
      emit(itype(6'h2B, 5'd0, 5'd10, 16'h58));
      run("z_halt");
      check("z_r0",      mem[16], 32'd0);
      check("z_slt_lt",  mem[17], 32'd1);
      check("z_slt_ge",  mem[18], 32'd0);
      check("z_sub",     mem[19], 32'd2);
      check("z_or",      mem[20], 32'd3);
      check("z_sll",     mem[21], 32'd48);
      check("z_and",     mem[22], 32'd2);
      check("z_retire",  ret_cnt, 32'd17);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_cpu.md
Name: multicycle_cpu

Overview:
Parametrised multi-cycle successor to the single-cycle MIPS core. It executes the same MIPS subset through a state machine over one shared instruction/data memory port. That port uses a req/ready handshake, so the core tolerates memories with any number of wait states. The register file, ALU, sign-extend and PC logic are internal; only the unified memory port and debug/status outputs are exposed.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
ADDR_W, 32, memory address width (1..32); mem_addr = low ADDR_W bits of the computed byte address.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = in reset).
mem_req  output  1  memory transaction request.
mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
mem_addr  output  ADDR_W  byte address; valid while mem_req=1.
mem_wdata  output  32  store data; valid while mem_req=1 and mem_we=1.
mem_ready  input  1  transaction completes on a rising edge where mem_req=1 and mem_ready=1.
mem_rdata  input  32  read data; sampled on the completing edge.
pc_out  output  32  current PC.
state_out  output  4  FSM state encoding (listed below).
retire  output  1  one-cycle pulse, registered, in the cycle after an instruction's final state.
halted  output  1  1 while in HALT.

Behaviour:
- Reset values (async on reset=0):
  - pc_out=RESET_PC; state=FETCH.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - retire=0, halted=0; all 32 registers = 0.
  - An in-flight transaction is abandoned.
  - First mem_req=1 occurs in the first cycle after reset releases.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until the completing edge.
  - mem_ready in the same cycle as the request is legal (zero wait).
  - mem_ready while mem_req=0 is ignored.
  - mem_req falls the cycle after completion unless the next state issues a new request.
- States (state_out code):
  - FETCH(0): req read at pc. On completion, latch IR=mem_rdata, pc<=pc+4, go to DECODE.
  - DECODE(1): read rs and rt into A and B; compute branch target = pc + (sext(imm16)<<2); dispatch on opcode:
    - 0x00 -> EXEC
    - 0x23 or 0x2B -> MEMADR
    - 0x04 -> BRANCH
    - 0x08 -> ADDIEX
    - 0x02 -> JUMP
    - otherwise -> HALT
  - MEMADR(2): ALUOut = A + sext(imm16). Next is MEMRD for lw, MEMWR for sw.
  - MEMRD(3): req read at ALUOut; latch MDR on completion; go to MEMWB.
  - MEMWB(4): rt <= MDR; go to FETCH.
  - MEMWR(5): req write of B at ALUOut; go to FETCH on completion.
  - EXEC(6): ALU on funct:
    - 0x20 add, 0x22 sub, 0x24 and, 0x25 or
    - 0x2A slt (signed; result 1 or 0)
    - 0x00 sll (rt << shamt)
    - any other funct -> HALT
  - ALUWB(7): rd <= ALUOut; go to FETCH.
  - BRANCH(8): if A==B, pc <= target; go to FETCH.
  - ADDIEX(9): ALUOut = A + sext(imm16).
  - ADDIWB(10): rt <= ALUOut; go to FETCH.
  - JUMP(11): pc <= {pc[31:28], imm26, 2'b00}, using the already-incremented pc; go to FETCH.
  - HALT(15): terminal. halted=1, no requests; exited only by reset.
- Cycle counts with zero-wait memory:
  - R-type 4, addi 4, lw 5, sw 4, beq 3, j 3.
  - Each wait cycle adds 1 to FETCH, MEMRD or MEMWR.
- Arithmetic:
  - 32-bit wrap-around with no overflow trap.
  - pc wraps at 2^32.
  - Unaligned addresses are passed through unchecked.
- Register $0:
  - Reads always return 0.
  - Writes to $0 are discarded.
- retire pulses for every completed instruction except one that goes to HALT.

Test Plan:
- Zero-wait program:
  - Program: addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sw $3,16($0); lw $4,16($0).
  - Required: mem[16]=12, $4=12, five retire pulses, total 4+4+4+4+5=21 cycles after the first fetch.
- Branches and jump:
  - beq $1,$1,+2 at PC 0x20 -> pc=0x2C.
  - beq with unequal operands -> pc=0x24.
  - j 0x40 at PC 0x30 -> pc=0x100.
  - Each takes 3 cycles.
- Wait states:
  - Memory holds mem_ready=0 for 3 cycles on every request.
  - Required: lw takes 11 cycles; mem_req, mem_addr and mem_we stay stable throughout each wait.
- Reset mid-operation:
  - Assert reset=0 during a waiting MEMWR at address 0x50.
  - Required: outputs go to reset values asynchronously, mem[0x50] is unchanged, and the next fetch after release is from RESET_PC.
- Illegal encodings:
  - Opcode 0x3F -> state_out=15, halted=1, no further mem_req, no retire.
  - R-type with funct 0x27 -> same result.
- $0 and slt:
  - addi $0,$0,9 -> $0 still reads 0.
  - slt with $1=-1 and $2=1 -> rd=1.
  - sll $5,$1,4 with $1=3 -> $5=48.
